uart_engine: RTL and testbench

UART_ENGINE -- requirements
Module: uart_engine

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_engine_if.sv | 23 ++
 rtl/uart_fifo.sv | 45 ++++
 rtl/uart_engine.sv | 186 ++++++++++++++++++
 tb/tb_uart_engine.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared encodings, FSM states and oversampling constants for the UART engine.
package uart_pkg;
    localparam int unsigned OVERSAMPLE   = 16;
    localparam int unsigned START_SAMPLE = 7;
    localparam int unsigned BIT_SAMPLE   = 15;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'd0,
        PAR_EVEN  = 2'd1,
        PAR_ODD   = 2'd2,
        PAR_NONE3 = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } fsm_state_e;

    function automatic logic parity_on(input parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic parity_bit(input logic [8:0] data, input parity_e mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction
endpackage

// File: rtl/uart_engine_if.sv
// Host-side FIFO access bundle of the UART engine.
interface uart_engine_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned FIFO_AW   = 4
);
    logic                 tx_wr_en;
    logic [DATA_BITS-1:0] tx_wr_data;
    logic                 tx_full;
    logic [FIFO_AW:0]     tx_level;
    logic                 rx_rd_en;
    logic [DATA_BITS-1:0] rx_rd_data;
    logic                 rx_empty;
    logic [FIFO_AW:0]     rx_level;

    modport master (
        output tx_wr_en, tx_wr_data, rx_rd_en,
        input  tx_full, tx_level, rx_rd_data, rx_empty, rx_level
    );
    modport slave (
        input  tx_wr_en, tx_wr_data, rx_rd_en,
        output tx_full, tx_level, rx_rd_data, rx_empty, rx_level
    );
endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO; full/empty are judged before the same-cycle push/pop.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             push;
    logic             pop;

    assign level   = wptr - rptr;
    assign full    = level[AW];
    assign empty   = (level == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rptr[AW-1:0]];

    // Storage is cleared so rd_data reads zero straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= wr_data;
                wptr              <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/uart_engine.sv
// UART engine: baud tick generator, TX/RX FIFOs and 16x oversampled TX/RX framers.
module uart_engine #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  divisor,
    input  logic [1:0]   parity_mode,
    input  logic         stop2,
    input  logic         rx_pin,
    output logic         tx_pin,
    output logic         tx_busy,
    output logic [2:0]   err_status,
    input  logic         err_clr,
    uart_engine_if.slave bus
);
    import uart_pkg::*;

    localparam int unsigned    TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  T_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0]  T_START   = TW'(START_SAMPLE);
    localparam logic [TW-1:0]  T_BIT     = TW'(BIT_SAMPLE);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);

    logic [15:0] baud_cnt;
    logic        tick;

    // '>=' lets a divisor reduced mid-count take effect without a counter wrap-around.
    assign tick = (baud_cnt >= divisor);

    always_ff @(posedge clk) begin
        if (reset) baud_cnt <= '0;
        else       baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
    end

    // ---------------- transmitter ----------------
    fsm_state_e           tx_state, tx_next;
    logic [TW-1:0]        tx_tcnt;
    logic [3:0]           tx_bcnt;
    logic [DATA_BITS-1:0] tx_shift, tx_fifo_data;
    logic                 tx_par, tx_par_en, tx_stop2;
    logic                 tx_bit_end, tx_last_stop, tx_load, tx_empty;

    assign tx_bit_end   = tick && (tx_tcnt == T_LAST);
    assign tx_last_stop = (tx_state == ST_STOP) && tx_bit_end && (tx_bcnt == {3'b000, tx_stop2});

    uart_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .reset(reset), .wr_en(bus.tx_wr_en), .wr_data(bus.tx_wr_data),
        .rd_en(tx_load), .rd_data(tx_fifo_data), .full(bus.tx_full), .empty(tx_empty),
        .level(bus.tx_level)
    );

    always_ff @(posedge clk) begin
        if (reset) tx_state <= ST_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            ST_IDLE:   if (tick && !tx_empty) tx_next = ST_START;
            ST_START:  if (tx_bit_end) tx_next = ST_DATA;
            ST_DATA:   if (tx_bit_end && tx_bcnt == LAST_DATA) tx_next = tx_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tx_bit_end) tx_next = ST_STOP;
            ST_STOP:   if (tx_last_stop) tx_next = tx_empty ? ST_IDLE : ST_START;
            default:   tx_next = ST_IDLE;
        endcase
    end

    // Loading at the end of the last stop bit gives back-to-back frames with no idle gap.
    always_comb begin
        tx_load = tick && !tx_empty && ((tx_state == ST_IDLE) || tx_last_stop);
        tx_busy = (tx_state != ST_IDLE);
        tx_pin  = 1'b1;
        case (tx_state)
            ST_START:  tx_pin = 1'b0;
            ST_DATA:   tx_pin = tx_shift[0];
            ST_PARITY: tx_pin = tx_par;
            default:   tx_pin = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_tcnt   <= '0;
            tx_bcnt   <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_par_en <= 1'b0;
            tx_stop2  <= 1'b0;
        end else if (tx_load) begin
            tx_tcnt   <= '0;
            tx_bcnt   <= '0;
            tx_shift  <= tx_fifo_data;
            tx_par    <= parity_bit(9'(tx_fifo_data), parity_e'(parity_mode));
            tx_par_en <= parity_on(parity_e'(parity_mode));
            tx_stop2  <= stop2;
        end else if (tick && tx_state != ST_IDLE) begin
            tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + 1'b1;
            if (tx_bit_end) begin
                tx_bcnt <= (tx_next != tx_state) ? '0 : tx_bcnt + 1'b1;
                if (tx_state == ST_DATA) tx_shift <= tx_shift >> 1;
            end
        end
    end

    // ---------------- receiver ----------------
    fsm_state_e           rx_state, rx_next;
    logic [1:0]           rx_sync;
    logic                 rx_prev, rxs, rx_fall;
    logic [TW-1:0]        rx_tcnt;
    logic [3:0]           rx_bcnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit, rx_samp, rx_push, rx_full;
    parity_e              rx_mode;
    logic                 ovr_set, par_set, frm_set;
    logic [2:0]           err_q;

    assign rxs        = rx_sync[1];
    assign rx_fall    = rx_prev && !rxs;
    assign rx_samp    = tick && (((rx_state == ST_START) && (rx_tcnt == T_START)) ||
                                 ((rx_state inside {ST_DATA, ST_PARITY, ST_STOP}) && (rx_tcnt == T_BIT)));
    assign err_status = err_q;

    uart_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .reset(reset), .wr_en(rx_push), .wr_data(rx_shift),
        .rd_en(bus.rx_rd_en), .rd_data(bus.rx_rd_data), .full(rx_full), .empty(bus.rx_empty),
        .level(bus.rx_level)
    );

    always_ff @(posedge clk) begin
        if (reset) rx_state <= ST_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            ST_IDLE:   if (rx_fall) rx_next = ST_START;
            ST_START:  if (rx_samp) rx_next = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:   if (rx_samp && rx_bcnt == LAST_DATA) rx_next = parity_on(rx_mode) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (rx_samp) rx_next = ST_STOP;
            ST_STOP:   if (rx_samp) rx_next = ST_IDLE;
            default:   rx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_push = rx_samp && (rx_state == ST_STOP);
        frm_set = rx_push && !rxs;
        par_set = rx_push && parity_on(rx_mode) && (rx_par_bit != parity_bit(9'(rx_shift), rx_mode));
        ovr_set = rx_push && rx_full;
    end

    // Sticky flags: a set in the same cycle as err_clr survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync    <= 2'b11;
            rx_prev    <= 1'b1;
            rx_tcnt    <= '0;
            rx_bcnt    <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
            rx_mode    <= PAR_NONE;
            err_q      <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rx_pin};
            rx_prev <= rxs;
            err_q   <= (err_q & ~{3{err_clr}}) | {ovr_set, par_set, frm_set};
            if (rx_state == ST_IDLE) begin
                rx_tcnt <= '0;
                rx_bcnt <= '0;
                if (rx_fall) rx_mode <= parity_e'(parity_mode);
            end else if (tick) begin
                rx_tcnt <= rx_samp ? '0 : rx_tcnt + 1'b1;
                if (rx_samp && rx_state == ST_DATA) begin
                    rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                    rx_bcnt  <= rx_bcnt + 1'b1;
                end
                if (rx_samp && rx_state == ST_PARITY) rx_par_bit <= rxs;
            end
        end
    end
endmodule

// File: tb/tb_uart_engine.sv
// Scoreboard bench for uart_engine: frame-level reference model, RX monitor drains and compares.
module tb_uart_engine;
    localparam int unsigned DB    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] divisor = '0;
    logic [1:0]  parity_mode = '0;
    logic        stop2 = 1'b0;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        err_clr = 1'b0;
    logic        rx_pin;
    logic        tx_pin;
    logic        tx_busy;
    logic [2:0]  err_status;

    uart_engine_if #(.DATA_BITS(DB), .FIFO_AW(AW)) bus ();

    assign rx_pin = loop ? tx_pin : rx_drv;

    uart_engine #(.DATA_BITS(DB), .FIFO_AW(AW), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .divisor(divisor), .parity_mode(parity_mode),
        .stop2(stop2), .rx_pin(rx_pin), .tx_pin(tx_pin), .tx_busy(tx_busy),
        .err_status(err_status), .err_clr(err_clr), .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    logic [DB-1:0] exp_q[$];
    logic [2:0]    model_err = '0;
    bit            mon_en = 1'b0;
    bit            fb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Line levels of one frame, derived from the framing rules.
    function automatic void build_frame(input logic [DB-1:0] d, input int pm, input bit s2,
                                        input bit bad_par, input bit bad_stop);
        bit p;
        fb.delete();
        fb.push_back(1'b0);
        for (int i = 0; i < DB; i++) fb.push_back(d[i]);
        p = ($countones(d) % 2) == 1;
        if (pm == 2) p = !p;
        if (pm == 1 || pm == 2) fb.push_back(p ^ bad_par);
        fb.push_back(!bad_stop);
        if (s2) fb.push_back(1'b1);
    endfunction

    // RX monitor: pops the scoreboard whenever the DUT presents a character.
    initial begin
        bus.rx_rd_en = 1'b0;
        forever begin
            @(negedge clk);
            bus.rx_rd_en = 1'b0;
            if (mon_en && !reset && !bus.rx_empty) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_unexpected: got %0h, expected no character", bus.rx_rd_data);
                end else begin
                    check("rx_data", 32'(bus.rx_rd_data), 32'(exp_q.pop_front()));
                end
                bus.rx_rd_en = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_err = '0;
    endtask

    task automatic push_tx(input logic [DB-1:0] d);
        bus.tx_wr_en   = 1'b1;
        bus.tx_wr_data = d;
        @(negedge clk);
        bus.tx_wr_en   = 1'b0;
    endtask

    task automatic wait_busy(input int unsigned limit);
        int unsigned k = 0;
        while (!tx_busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (k >= limit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_start_timeout: tx_busy=0 after %0d cycles, expected 1", limit);
        end
    endtask

    task automatic wait_tx_idle(input int unsigned limit);
        int unsigned k = 0;
        while ((tx_busy || bus.tx_level != 0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (k >= limit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_idle_timeout: busy after %0d cycles, expected idle", limit);
        end
    endtask

    task automatic check_tx_wave(input logic [DB-1:0] d, input int pm, input bit s2);
        int unsigned errs = 0;
        int unsigned len;
        build_frame(d, pm, s2, 1'b0, 1'b0);
        len = fb.size() * 16;
        parity_mode = 2'(pm);
        stop2 = s2;
        push_tx(d);
        wait_busy(100);
        for (int unsigned c = 0; c < len; c++) begin
            if (tx_pin !== fb[c / 16] || tx_busy !== 1'b1) errs++;
            @(negedge clk);
        end
        check("tx_wave_cycles_wrong", errs, 0);
        check("tx_busy_pin_after_frame", {30'd0, tx_busy, tx_pin}, 32'b01);
    endtask

    task automatic send_rx(input logic [DB-1:0] d, input int pm, input bit s2,
                           input bit bad_par, input bit bad_stop);
        int unsigned blen = 16 * (int'(divisor) + 1);
        parity_mode = 2'(pm);
        stop2 = s2;
        build_frame(d, pm, s2, bad_par, bad_stop);
        if (exp_q.size() >= DEPTH) model_err[2] = 1'b1;
        else exp_q.push_back(d);
        if ((pm == 1 || pm == 2) && bad_par) model_err[1] = 1'b1;
        if (bad_stop) model_err[0] = 1'b1;
        foreach (fb[i]) begin
            rx_drv = fb[i];
            cycles(blen);
        end
        rx_drv = 1'b1;
        cycles(blen);
    endtask

    task automatic clear_errors();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_err = '0;
        check("err_after_clr", 32'(err_status), 32'(model_err));
    endtask

    task automatic loop_burst(input int unsigned dv, input int pm, input bit s2, input int unsigned n);
        logic [DB-1:0] d;
        divisor = 16'(dv);
        parity_mode = 2'(pm);
        stop2 = s2;
        loop = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        for (int unsigned i = 0; i < n; i++) begin
            d = DB'($urandom_range(0, 255));
            exp_q.push_back(d);
            push_tx(d);
        end
        wait_tx_idle(n * 12 * 16 * (dv + 1) + 400);
        cycles(40);
        check("rx_drain_count", exp_q.size(), 0);
        check("err_after_loopback", 32'(err_status), 32'(model_err));
    endtask

    initial begin
        logic [DB-1:0] d;
        bus.tx_wr_en   = 1'b0;
        bus.tx_wr_data = '0;
        cycles(3);
        check("rst_tx_pin", 32'(tx_pin), 1);
        check("rst_tx_busy", 32'(tx_busy), 0);
        check("rst_tx_full", 32'(bus.tx_full), 0);
        check("rst_rx_empty", 32'(bus.rx_empty), 1);
        check("rst_tx_level", 32'(bus.tx_level), 0);
        check("rst_rx_level", 32'(bus.rx_level), 0);
        check("rst_err", 32'(err_status), 0);
        check("rst_rx_rd_data", 32'(bus.rx_rd_data), 0);
        reset = 1'b0;
        cycles(2);

        // Exact TX waveforms at one tick per clock.
        divisor = '0;
        check_tx_wave(8'hA5, 0, 1'b0);
        check_tx_wave(8'h3C, 1, 1'b1);
        check_tx_wave(DB'($urandom_range(0, 255)), 2, 1'b0);
        check_tx_wave(DB'($urandom_range(0, 255)), 3, 1'b1);

        // Loopback: known pair, then random configurations.
        divisor = '0;
        parity_mode = 2'd1;
        stop2 = 1'b1;
        loop = 1'b1;
        mon_en = 1'b1;
        exp_q.push_back(8'h3C);
        push_tx(8'h3C);
        exp_q.push_back(8'hFF);
        push_tx(8'hFF);
        wait_tx_idle(1000);
        cycles(40);
        check("rx_drain_3c_ff", exp_q.size(), 0);
        check("err_3c_ff", 32'(err_status), 0);
        for (int b = 0; b < 6; b++)
            loop_burst($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       $urandom_range(1, 5));

        // Driven RX frames: parity error, framing error, clean random frames.
        loop = 1'b0;
        divisor = 16'($urandom_range(0, 1));
        send_rx(8'h55, 2, 1'b0, 1'b1, 1'b0);
        cycles(20);
        check("rx_drain_par", exp_q.size(), 0);
        check("err_parity", 32'(err_status), 32'(model_err));
        clear_errors();
        send_rx(DB'($urandom_range(0, 255)), 0, 1'b0, 1'b0, 1'b1);
        cycles(20);
        check("err_framing", 32'(err_status), 32'(model_err));
        clear_errors();
        for (int i = 0; i < 4; i++)
            send_rx(DB'($urandom_range(0, 255)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        cycles(20);
        check("rx_drain_driven", exp_q.size(), 0);
        check("err_driven_clean", 32'(err_status), 32'(model_err));

        // False start: line low for 4 ticks only.
        divisor = '0;
        rx_drv = 1'b0;
        cycles(4);
        rx_drv = 1'b1;
        cycles(400);
        check("false_start_level", 32'(bus.rx_level), 0);
        check("false_start_err", 32'(err_status), 0);

        // Overrun: 17 characters with no reads.
        mon_en = 1'b0;
        for (int i = 0; i < 17; i++) send_rx(DB'($urandom_range(0, 255)), 0, 1'b0, 1'b0, 1'b0);
        check("overrun_level", 32'(bus.rx_level), exp_q.size());
        check("overrun_err", 32'(err_status), 32'(model_err));
        mon_en = 1'b1;
        cycles(60);
        check("overrun_drain", exp_q.size(), 0);
        clear_errors();

        // TX FIFO full boundary: ticks held off by a huge divisor.
        mon_en = 1'b0;
        divisor = 16'hFFFF;
        do_reset();
        for (int i = 0; i < 17; i++) push_tx(DB'($urandom_range(0, 255)));
        check("tx_full_flag", 32'(bus.tx_full), 1);
        check("tx_full_level", 32'(bus.tx_level), DEPTH);

        // Reset in the middle of a TX frame with three characters queued.
        divisor = '0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d = DB'($urandom_range(0, 255));
            push_tx(d);
        end
        wait_busy(100);
        cycles(48);
        check("pre_reset_tx_level", 32'(bus.tx_level), 3);
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx_pin", 32'(tx_pin), 1);
        check("abort_tx_level", 32'(bus.tx_level), 0);
        check("abort_tx_busy", 32'(tx_busy), 0);
        reset = 1'b0;
        cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
